mpu_bus_initiator: RTL
======================

Name: mpu_bus_initiator

Overview:
- Synchronous 68000-style bus-cycle initiator: the master end of the AS/UDS/LDS/WR/DTACK/BERR/AVEC bus that the existing bus controller answers as responder.
- Takes single read, write and interrupt-acknowledge commands from an on-chip client (debug loader, DMA, bench CPU model) and returns data and a status.
- Sits in front of the same address map and drives the same active-high internal strobe signals the responder consumes.

Parameters:
- TIMEOUT_CYCLES, 64: wait-state limit, counted from strobe assertion, before the cycle aborts with TIMEOUT.
- ACK_HOLDOFF, 1: cycles after strobe assertion during which DATA_ACK, BUS_ERROR_ACK and INT_AUTOVEC_ACK are ignored. This covers the responder's registered decode.
- FC_DATA, 3'b101: status code driven for normal data cycles.

Ports:
- CPUCLK_IN in 1: clock; all logic on rising edge.
- RESET_IN in 1: synchronous, active-high reset.
- CMD_VALID in 1: command request.
- CMD_READY out 1: command accepted when high together with CMD_VALID.
- CMD_WRITE in 1: 1 = write, 0 = read.
- CMD_WORD in 1: 1 = 16-bit, 0 = byte.
- CMD_INTACK in 1: interrupt-acknowledge cycle; overrides CMD_WRITE and CMD_WORD.
- CMD_ADDR in 24: byte address; for INTACK, [3:1] = level.
- CMD_WDATA in 16: write data; byte writes use [7:0].
- RSP_VALID out 1: response available.
- RSP_READY in 1: response consumed.
- RSP_RDATA out 16: read data, or vector in [7:0].
- RSP_STATUS out 3: 0 OK, 1 BERR, 2 TIMEOUT, 3 ADDRERR, 4 AUTOVEC.
- ADDR out 24: bus address.
- MPU_STATUS_CODE out 3: function code.
- AS out 1: address strobe.
- UDS out 1: upper data strobe.
- LDS out 1: lower data strobe.
- WR out 1: write.
- DATA_OUT out 16: write data.
- DATA_OE out 1: top-level tri-state enable for DATA.
- DATA_IN in 16: bus read data.
- DATA_ACK in 1: DTACK.
- BUS_ERROR_ACK in 1: BERR.
- INT_AUTOVEC_ACK in 1: AVEC.

Behaviour:
- Reset: state IDLE; CMD_READY=0 during reset, 1 afterwards. RSP_VALID=0, RSP_RDATA=0, RSP_STATUS=0, ADDR=0, MPU_STATUS_CODE=0, AS=UDS=LDS=WR=0, DATA_OUT=0, DATA_OE=0. Reset mid-cycle drops strobes and any pending response at that edge.
- States: IDLE, ADDR, STROBE, WAIT, RECOVER, RESP.
- IDLE:
  - CMD_READY=1 only here.
  - Accept on CMD_VALID&CMD_READY.
  - A word access at an odd address (CMD_WORD & CMD_ADDR[0], not INTACK) runs no bus cycle: RESP with ADDRERR next edge.
  - All other commands go to ADDR.
- ADDR (1 cycle):
  - ADDR=CMD_ADDR; MPU_STATUS_CODE=FC_DATA; WR=CMD_WRITE.
  - Write: DATA_OUT = word ? CMD_WDATA : {CMD_WDATA[7:0],CMD_WDATA[7:0]}; DATA_OE=1.
  - INTACK: ADDR={20'hFFFFF,level,1'b1}; MPU_STATUS_CODE=3'b111; WR=0.
- STROBE (entered the next edge):
  - AS=1.
  - Word or INTACK: UDS=LDS=1. Byte at even address: UDS only. Byte at odd address: LDS only.
  - Timeout counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments each cycle; acks are ignored while counter < ACK_HOLDOFF.
  - Priority at a sampling edge: BUS_ERROR_ACK > INT_AUTOVEC_ACK (INTACK only; ignored otherwise) > DATA_ACK > timeout.
  - Counter == TIMEOUT_CYCLES-1 with no ack: TIMEOUT.
  - On termination: AS/UDS/LDS=0 at that edge; RSP fields latched; RSP_VALID=1; go to RECOVER.
  - Read data: word = DATA_IN; byte = zero-extended DATA_IN[15:8] (even) or DATA_IN[7:0] (odd).
  - INTACK via DTACK: RSP_RDATA={8'h00,DATA_IN[7:0]}, OK. Via AVEC: RSP_RDATA=24+level, status AUTOVEC.
  - BERR and TIMEOUT: RSP_RDATA=0.
- RECOVER:
  - DATA_OE=0, WR=0, MPU_STATUS_CODE=0 on entry.
  - Stay until DATA_ACK, BUS_ERROR_ACK and INT_AUTOVEC_ACK all sample low, then go to RESP.
  - RSP_VALID may already be high here; RSP_READY is honoured in RECOVER or RESP.
- RESP:
  - Wait until the response is consumed (RSP_VALID&RSP_READY clears RSP_VALID), then go to IDLE.
  - RSP_RDATA and RSP_STATUS stay stable while RSP_VALID=1.
- Latency with ACK_HOLDOFF=1 and immediate ack: accept edge N; AS high after N+2; RSP_VALID high after N+4. Minimum command-to-command spacing is 6 cycles.
- Counter width: clog2(TIMEOUT_CYCLES)+1. It never wraps.

Test Plan:
- Word write 0x1234 to 0x000100; DATA_ACK responds 2 cycles after AS. Expect:
  - AS/UDS/LDS high together.
  - DATA_OUT=0x1234 and DATA_OE=1 from ADDR through WAIT.
  - RSP_STATUS=0.
  - Strobes low at the termination edge.
- Byte read at 0x100007 with DATA_IN=0x55AA. Expect LDS only, UDS=0, RSP_RDATA=0x00AA, OK. Byte write 0x3C at 0x100005 drives DATA_OUT=0x3C3C with LDS only.
- BUS_ERROR_ACK held high from strobe assertion, DATA_ACK rising one cycle later. With holdoff=1, BERR is sampled at the first legal edge: status 1 (BERR wins). With BERR low during holdoff and DATA_ACK high after it: OK.
- No ack ever:
  - TIMEOUT status exactly TIMEOUT_CYCLES cycles after the STROBE entry edge.
  - Strobes drop.
  - With TIMEOUT_CYCLES=4, RSP_VALID rises at the 4th WAIT edge.
- INTACK level 2:
  - ADDR=0xFFFFF5, MPU_STATUS_CODE=7, UDS=LDS=1.
  - AVEC response: RSP_RDATA=26, status 4.
  - DTACK response with DATA_IN=0x0040: RSP_RDATA=0x0040, status 0.
- Word read at 0x000003: ADDRERR, AS never asserts. Additional checks:
  - RESET_IN pulsed during WAIT: all bus outputs 0 next edge, RSP_VALID=0.
  - DATA_ACK held high after termination: state stays RECOVER, CMD_READY stays 0 until it falls.

Source files
------------

// File: rtl/mpu_bus_initiator.sv
// 68000-style bus-cycle initiator: turns single read/write/INTACK commands
// into AS/UDS/LDS/WR strobe cycles and returns data plus a completion status.
module mpu_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ACK_HOLDOFF    = 1,
    parameter logic [2:0]  FC_DATA        = 3'b101
) (
    input  logic        CPUCLK_IN,
    input  logic        RESET_IN,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic        CMD_WORD,
    input  logic        CMD_INTACK,
    input  logic [23:0] CMD_ADDR,
    input  logic [15:0] CMD_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_RDATA,
    output logic [2:0]  RSP_STATUS,
    output logic [23:0] ADDR,
    output logic [2:0]  MPU_STATUS_CODE,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        WR,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DATA_ACK,
    input  logic        BUS_ERROR_ACK,
    input  logic        INT_AUTOVEC_ACK
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HOLDOFF_C  = CNT_W'(ACK_HOLDOFF);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_BERR    = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd2;
    localparam logic [2:0] ST_ADDRERR = 3'd3;
    localparam logic [2:0] ST_AUTOVEC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Latched command
    logic              cmd_write_q, cmd_write_d;
    logic              cmd_word_q, cmd_word_d;
    logic              cmd_intack_q, cmd_intack_d;
    logic [23:0]       cmd_addr_q, cmd_addr_d;
    logic [15:0]       cmd_wdata_q, cmd_wdata_d;

    // Registered outputs
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic [23:0]       addr_q, addr_d;
    logic [2:0]        fc_q, fc_d;
    logic              as_q, as_d;
    logic              uds_q, uds_d;
    logic              lds_q, lds_d;
    logic              wr_q, wr_d;
    logic [15:0]       dout_q, dout_d;
    logic              doe_q, doe_d;

    // Termination decode inside WAIT
    logic              ack_open_c;
    logic              term_c;
    logic [2:0]        term_status_c;
    logic [15:0]       term_data_c;
    logic [15:0]       read_data_c;

    // Read-data lane selection for a DTACK-terminated cycle
    always_comb begin
        read_data_c = 16'h0000;
        if (cmd_intack_q) begin
            read_data_c = {8'h00, DATA_IN[7:0]};
        end else if (cmd_word_q) begin
            read_data_c = DATA_IN;
        end else if (cmd_addr_q[0]) begin
            read_data_c = {8'h00, DATA_IN[7:0]};
        end else begin
            read_data_c = {8'h00, DATA_IN[15:8]};
        end
    end

    // Wait-state termination priority: BERR > AVEC (INTACK only) > DTACK > timeout
    always_comb begin
        ack_open_c    = (cnt_q >= HOLDOFF_C);
        term_c        = 1'b0;
        term_status_c = ST_OK;
        term_data_c   = 16'h0000;
        if (ack_open_c && BUS_ERROR_ACK) begin
            term_c        = 1'b1;
            term_status_c = ST_BERR;
        end else if (ack_open_c && cmd_intack_q && INT_AUTOVEC_ACK) begin
            term_c        = 1'b1;
            term_status_c = ST_AUTOVEC;
            term_data_c   = 16'd24 + 16'(cmd_addr_q[3:1]);
        end else if (ack_open_c && DATA_ACK) begin
            term_c        = 1'b1;
            term_status_c = ST_OK;
            term_data_c   = cmd_write_q ? 16'h0000 : read_data_c;
        end else if (cnt_q == TMO_LAST_C) begin
            term_c        = 1'b1;
            term_status_c = ST_TIMEOUT;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_write_d  = cmd_write_q;
        cmd_word_d   = cmd_word_q;
        cmd_intack_d = cmd_intack_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        addr_d       = addr_q;
        fc_d         = fc_q;
        as_d         = as_q;
        uds_d        = uds_q;
        lds_d        = lds_q;
        wr_d         = wr_q;
        dout_d       = dout_q;
        doe_d        = doe_q;
        cmd_ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_write_d  = CMD_WRITE & ~CMD_INTACK;
                    cmd_word_d   = CMD_WORD;
                    cmd_intack_d = CMD_INTACK;
                    cmd_addr_d   = CMD_ADDR;
                    cmd_wdata_d  = CMD_WDATA;
                    if (CMD_WORD && CMD_ADDR[0] && !CMD_INTACK) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_ADDRERR;
                        rsp_rdata_d  = 16'h0000;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (cmd_intack_q) begin
                    addr_d = {20'hFFFFF, cmd_addr_q[3:1], 1'b1};
                    fc_d   = 3'b111;
                    wr_d   = 1'b0;
                    doe_d  = 1'b0;
                end else begin
                    addr_d = cmd_addr_q;
                    fc_d   = FC_DATA;
                    wr_d   = cmd_write_q;
                    doe_d  = cmd_write_q;
                    if (cmd_write_q) begin
                        dout_d = cmd_word_q ? cmd_wdata_q
                                            : {cmd_wdata_q[7:0], cmd_wdata_q[7:0]};
                    end
                end
                state_d = S_STROBE;
            end
            S_STROBE: begin
                as_d    = 1'b1;
                uds_d   = cmd_word_q | cmd_intack_q | ~cmd_addr_q[0];
                lds_d   = cmd_word_q | cmd_intack_q | cmd_addr_q[0];
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (term_c) begin
                    as_d         = 1'b0;
                    uds_d        = 1'b0;
                    lds_d        = 1'b0;
                    wr_d         = 1'b0;
                    doe_d        = 1'b0;
                    fc_d         = 3'b000;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = term_status_c;
                    rsp_rdata_d  = term_data_c;
                    state_d      = S_RECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (rsp_valid_q && RSP_READY) begin
                    rsp_valid_d = 1'b0;
                end
                if (!DATA_ACK && !BUS_ERROR_ACK && !INT_AUTOVEC_ACK) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q || RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cmd_write_q  <= 1'b0;
            cmd_word_q   <= 1'b0;
            cmd_intack_q <= 1'b0;
            cmd_addr_q   <= 24'h000000;
            cmd_wdata_q  <= 16'h0000;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'h0000;
            rsp_status_q <= 3'b000;
            addr_q       <= 24'h000000;
            fc_q         <= 3'b000;
            as_q         <= 1'b0;
            uds_q        <= 1'b0;
            lds_q        <= 1'b0;
            wr_q         <= 1'b0;
            dout_q       <= 16'h0000;
            doe_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_write_q  <= cmd_write_d;
            cmd_word_q   <= cmd_word_d;
            cmd_intack_q <= cmd_intack_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            addr_q       <= addr_d;
            fc_q         <= fc_d;
            as_q         <= as_d;
            uds_q        <= uds_d;
            lds_q        <= lds_d;
            wr_q         <= wr_d;
            dout_q       <= dout_d;
            doe_q        <= doe_d;
        end
    end

    assign CMD_READY       = cmd_ready_q;
    assign RSP_VALID       = rsp_valid_q;
    assign RSP_RDATA       = rsp_rdata_q;
    assign RSP_STATUS      = rsp_status_q;
    assign ADDR            = addr_q;
    assign MPU_STATUS_CODE = fc_q;
    assign AS              = as_q;
    assign UDS             = uds_q;
    assign LDS             = lds_q;
    assign WR              = wr_q;
    assign DATA_OUT        = dout_q;
    assign DATA_OE         = doe_q;

endmodule
